// File: rtl/sobel_frame_sequencer.sv
// Streams one Avalon-ST frame into the Sobel core, starts it, waits for done, and streams the result out.
// Sink writes are combinational with the accepted beat; the source starts 2 edges after done is sampled and holds its beat while stalled.
module sobel_frame_sequencer #(
    parameter int  IMG_X_SIZE = 320,
    parameter int  IMG_Y_SIZE = 240,
    parameter int  CNT_W      = 16,
    localparam int N          = IMG_X_SIZE * IMG_Y_SIZE,
    localparam int ADDR_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic              csi_clkrst_clk,
    input  logic              csi_clkrst_reset,
    input  logic [7:0]        asi_sink1_data,
    input  logic              asi_sink1_startofpacket,
    input  logic              asi_sink1_endofpacket,
    input  logic              asi_sink1_valid,
    output logic              asi_sink1_ready,
    input  logic              aso_source1_ready,
    output logic [7:0]        aso_source1_data,
    output logic              aso_source1_startofpacket,
    output logic              aso_source1_endofpacket,
    output logic              aso_source1_valid,
    output logic              core_wr_en_o,
    output logic [ADDR_W-1:0] core_wr_addr_o,
    output logic [7:0]        core_wr_data_o,
    output logic              core_start_o,
    input  logic              core_done_i,
    output logic [ADDR_W-1:0] core_rd_addr_o,
    input  logic [7:0]        core_rd_data_i,
    output logic              frame_err_o,
    output logic [CNT_W-1:0]  frame_cnt_o
);

    // One extra counter bit so the read pointer can reach N when N is a power of two.
    localparam int            CW     = ADDR_W + 1;
    localparam logic [CW-1:0] N_C    = CW'(N);
    localparam logic [CW-1:0] LAST_C = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DISCARD,
        S_START,
        S_PROC,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic [7:0] dat;
        logic       sop;
        logic       eop;
    } beat_t;

    state_t           state;
    logic [CW-1:0]    pix_cnt;
    logic [CW-1:0]    rd_cnt;
    logic [1:0]       occ;
    logic             inflight;
    logic             infl_sop;
    logic             infl_eop;
    beat_t            ent0;
    beat_t            ent1;
    logic             frame_err_q;
    logic [CNT_W-1:0] frame_cnt_q;

    logic             sink_beat;
    logic             new_frame;
    logic             pix_in_frame;
    logic [CW-1:0]    pix_idx;
    logic [CW-1:0]    pix_nxt;
    logic             pop;
    logic             push;
    logic [2:0]       lvl;
    logic             issue;
    logic             last_pop;
    beat_t            new_ent;

    assign asi_sink1_ready = (state == S_IDLE) || (state == S_LOAD) || (state == S_DISCARD);
    assign sink_beat       = asi_sink1_valid & asi_sink1_ready;
    assign new_frame       = sink_beat & asi_sink1_startofpacket &
                             ((state == S_IDLE) || (state == S_LOAD));
    assign pix_in_frame    = new_frame | (sink_beat & (state == S_LOAD));
    assign pix_idx         = new_frame ? '0 : pix_cnt;
    assign pix_nxt         = pix_idx + CW'(1);

    assign core_wr_en_o    = pix_in_frame;
    assign core_wr_addr_o  = pix_idx[ADDR_W-1:0];
    assign core_wr_data_o  = asi_sink1_data;
    assign core_start_o    = (state == S_START);
    assign core_rd_addr_o  = rd_cnt[ADDR_W-1:0];

    assign aso_source1_valid         = (occ != 2'd0);
    assign aso_source1_data          = ent0.dat;
    assign aso_source1_startofpacket = ent0.sop;
    assign aso_source1_endofpacket   = ent0.eop;
    assign frame_err_o               = frame_err_q;
    assign frame_cnt_o               = frame_cnt_q;

    // Reads are only issued when the buffer is guaranteed room for the returning data.
    assign pop      = aso_source1_valid & aso_source1_ready;
    assign push     = inflight;
    assign lvl      = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign issue    = (state == S_DRAIN) && (rd_cnt < N_C) && (lvl < 3'd2);
    assign last_pop = pop & ent0.eop;
    assign new_ent  = {core_rd_data_i, infl_sop, infl_eop};

    always_ff @(posedge csi_clkrst_clk) begin
        if (csi_clkrst_reset) begin
            state       <= S_IDLE;
            pix_cnt     <= '0;
            rd_cnt      <= '0;
            occ         <= 2'd0;
            inflight    <= 1'b0;
            infl_sop    <= 1'b0;
            infl_eop    <= 1'b0;
            ent0        <= '0;
            ent1        <= '0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            frame_err_q <= 1'b0;

            if (pix_in_frame) begin
                if ((state == S_LOAD) && asi_sink1_startofpacket) begin
                    frame_err_q <= 1'b1;
                end
                if (asi_sink1_endofpacket) begin
                    pix_cnt <= '0;
                    if (pix_nxt == N_C) begin
                        state <= S_START;
                    end else begin
                        frame_err_q <= 1'b1;
                        state       <= S_IDLE;
                    end
                end else if (pix_nxt == N_C) begin
                    pix_cnt <= '0;
                    state   <= S_DISCARD;
                end else begin
                    pix_cnt <= pix_nxt;
                    state   <= S_LOAD;
                end
            end

            case (state)
                S_DISCARD: begin
                    if (sink_beat && asi_sink1_endofpacket) begin
                        frame_err_q <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                S_START: state <= S_PROC;
                S_PROC: begin
                    if (core_done_i) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (last_pop) begin
                        state       <= S_IDLE;
                        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase

            inflight <= issue;
            if (issue) begin
                infl_sop <= (rd_cnt == '0);
                infl_eop <= (rd_cnt == LAST_C);
                rd_cnt   <= rd_cnt + CW'(1);
            end

            if (pop) begin
                if (occ == 2'd2) begin
                    ent0 <= ent1;
                    if (push) begin
                        ent1 <= new_ent;
                    end
                end else if (push) begin
                    ent0 <= new_ent;
                end
            end else if (push) begin
                if (occ == 2'd0) begin
                    ent0 <= new_ent;
                end else begin
                    ent1 <= new_ent;
                end
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};

            if (last_pop) begin
                rd_cnt   <= '0;
                occ      <= 2'd0;
                inflight <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Directed bench for sobel_frame_sequencer on a 4x3 frame with a delayed-done, inverted-address core model.
module tb_sobel_frame_sequencer;

    localparam int N  = 12;
    localparam int AW = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    sink_data = 8'd0;
    logic          sink_sop = 1'b0;
    logic          sink_eop = 1'b0;
    logic          sink_valid = 1'b0;
    logic          sink_ready;
    logic          src_ready = 1'b1;
    logic [7:0]    src_data;
    logic          src_sop;
    logic          src_eop;
    logic          src_valid;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          start;
    logic          done = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data = 8'd0;
    logic          err;
    logic [CW-1:0] frame_cnt;

    always #5 clk = ~clk;

    sobel_frame_sequencer #(
        .IMG_X_SIZE(4),
        .IMG_Y_SIZE(3),
        .CNT_W(CW)
    ) dut (
        .csi_clkrst_clk(clk),
        .csi_clkrst_reset(rst),
        .asi_sink1_data(sink_data),
        .asi_sink1_startofpacket(sink_sop),
        .asi_sink1_endofpacket(sink_eop),
        .asi_sink1_valid(sink_valid),
        .asi_sink1_ready(sink_ready),
        .aso_source1_ready(src_ready),
        .aso_source1_data(src_data),
        .aso_source1_startofpacket(src_sop),
        .aso_source1_endofpacket(src_eop),
        .aso_source1_valid(src_valid),
        .core_wr_en_o(wr_en),
        .core_wr_addr_o(wr_addr),
        .core_wr_data_o(wr_data),
        .core_start_o(start),
        .core_done_i(done),
        .core_rd_addr_o(rd_addr),
        .core_rd_data_i(rd_data),
        .frame_err_o(err),
        .frame_cnt_o(frame_cnt)
    );

    // Core model: done pulses 10 cycles after start, result pixel = address ^ 8'hFF.
    int tmr = 0;
    always @(posedge clk) begin
        rd_data <= {4'h0, rd_addr} ^ 8'hFF;
        done    <= 1'b0;
        if (start) begin
            tmr <= 10;
        end else if (tmr > 0) begin
            tmr <= tmr - 1;
            if (tmr == 1) done <= 1'b1;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int exp_wa[$];
    int exp_wd[$];
    bit rdy_q[$];

    always @(posedge clk) begin
        #1;
        if (rdy_q.size() == 0) src_ready = 1'b1;
        else if (src_valid) src_ready = rdy_q.pop_front();
    end

    int out_idx = 0;
    int beats = 0;
    int err_cnt = 0;
    int start_cnt = 0;
    int done_cyc = 0;
    int first_dat = -1;
    int last_dat = -1;
    bit prev_v = 0;
    bit prev_r = 0;
    int prev_d = 0;
    bit prev_s = 0;
    bit prev_e = 0;

    always @(negedge clk) begin
        if (rst) begin
            out_idx = 0;
            prev_v  = 0;
        end else begin
            if (wr_en) begin
                if (exp_wa.size() == 0) begin
                    chk("unexpected_write", int'(wr_addr), -1);
                end else begin
                    chk("wr_addr", int'(wr_addr), exp_wa.pop_front());
                    chk("wr_data", int'(wr_data), exp_wd.pop_front());
                end
            end
            if (err) err_cnt++;
            if (start) start_cnt++;
            if (done) done_cyc = cyc;
            if (start || src_valid) chk("sink_ready_busy", int'(sink_ready), 0);
            if (prev_v && !prev_r) begin
                chk("stall_valid", int'(src_valid), 1);
                chk("stall_data", int'(src_data), prev_d);
                chk("stall_sop", int'(src_sop), int'(prev_s));
                chk("stall_eop", int'(src_eop), int'(prev_e));
            end
            if (src_valid && !prev_v && out_idx == 0)
                chk("first_valid_latency", cyc - done_cyc, 3);
            if (src_valid && src_ready) begin
                chk("out_data", int'(src_data), 255 - out_idx);
                chk("out_sop", int'(src_sop), int'(out_idx == 0));
                chk("out_eop", int'(src_eop), int'(out_idx == N - 1));
                if (out_idx == 0) first_dat = int'(src_data);
                last_dat = int'(src_data);
                beats++;
                out_idx = (out_idx == N - 1) ? 0 : out_idx + 1;
            end
            prev_v = src_valid;
            prev_r = src_ready;
            prev_d = int'(src_data);
            prev_s = src_sop;
            prev_e = src_eop;
        end
    end

    task automatic send(input int d, input bit s, input bit e);
        bit acc = 0;
        int t = 0;
        sink_data  = 8'(d);
        sink_sop   = s;
        sink_eop   = e;
        sink_valid = 1'b1;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = sink_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) chk("send_timeout", 0, 1);
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
    endtask

    task automatic send_frame(input int base);
        for (int i = 0; i < N; i++) begin
            exp_wa.push_back(i);
            exp_wd.push_back(base + i);
            send(base + i, i == 0, i == N - 1);
        end
    endtask

    task automatic wait_frames(input int exp);
        int t = 0;
        while (int'(frame_cnt) != exp && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("frame_cnt", int'(frame_cnt), exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    int e0, s0, b0;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sink_ready", int'(sink_ready), 1);
        chk("rst_src_valid", int'(src_valid), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_start", int'(start), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // T1: nominal frame
        e0 = err_cnt; s0 = start_cnt; b0 = beats;
        send_frame(0);
        wait_frames(1);
        idle(2);
        chk("t1_starts", start_cnt - s0, 1);
        chk("t1_errs", err_cnt - e0, 0);
        chk("t1_beats", beats - b0, 12);
        chk("t1_first_dat", first_dat, 8'hFF);
        chk("t1_last_dat", last_dat, 8'hF4);
        chk("t1_writes_left", exp_wa.size(), 0);

        // T2: short packet, then a good one
        e0 = err_cnt; s0 = start_cnt;
        for (int i = 0; i < 7; i++) begin
            exp_wa.push_back(i);
            exp_wd.push_back(20 + i);
            send(20 + i, i == 0, i == 6);
        end
        idle(5);
        chk("t2_errs", err_cnt - e0, 1);
        chk("t2_starts", start_cnt - s0, 0);
        chk("t2_frame_cnt", int'(frame_cnt), 1);
        chk("t2_sink_ready", int'(sink_ready), 1);
        chk("t2_writes_left", exp_wa.size(), 0);
        send_frame(30);
        wait_frames(2);

        // T3: overlong packet
        e0 = err_cnt; s0 = start_cnt;
        for (int i = 0; i < 15; i++) begin
            if (i < N) begin
                exp_wa.push_back(i);
                exp_wd.push_back(40 + i);
            end
            send(40 + i, i == 0, i == 14);
        end
        idle(5);
        chk("t3_errs", err_cnt - e0, 1);
        chk("t3_starts", start_cnt - s0, 0);
        chk("t3_frame_cnt", int'(frame_cnt), 2);
        chk("t3_writes_left", exp_wa.size(), 0);

        // T4: source backpressure 1010... then 5 low cycles
        b0 = beats;
        rdy_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        send_frame(60);
        wait_frames(3);
        idle(2);
        chk("t4_beats", beats - b0, 12);
        chk("t4_pattern_used", rdy_q.size(), 0);

        // T5: reset in the middle of the output stream
        send_frame(80);
        begin
            int t = 0;
            while (out_idx != 5 && t < 300) begin
                @(negedge clk);
                t++;
            end
            chk("t5_reach_beat5", out_idx, 5);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_src_valid", int'(src_valid), 0);
        chk("t5_sink_ready", int'(sink_ready), 1);
        chk("t5_frame_cnt", int'(frame_cnt), 0);
        @(posedge clk);
        #1;
        e0 = err_cnt;
        send_frame(90);
        wait_frames(1);
        chk("t5_errs", err_cnt - e0, 0);

        // T6: stray beats before sop, then sop restart mid-frame
        e0 = err_cnt; s0 = start_cnt;
        send(100, 0, 0);
        send(101, 0, 0);
        send(102, 0, 0);
        for (int i = 0; i < 3; i++) begin
            exp_wa.push_back(i);
            exp_wd.push_back(i);
            send(i, i == 0, 0);
        end
        for (int i = 0; i < N; i++) begin
            exp_wa.push_back(i);
            exp_wd.push_back(50 + i);
            send(50 + i, i == 0, i == N - 1);
        end
        wait_frames(2);
        idle(2);
        chk("t6_errs", err_cnt - e0, 1);
        chk("t6_starts", start_cnt - s0, 1);
        chk("t6_writes_left", exp_wa.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
